// File: rtl/subtractor_pkg.sv
// Shared definitions for the serial subtractor slice.
//   state_t       : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   DEFAULT_WIDTH : default operand/result width in bits
package subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor: computes x - y for single bits.
//   x  : minuend bit
//   y  : subtrahend bit
//   d  : difference bit (x ^ y)
//   bo : borrow out, set when y exceeds x
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. A start pulse in IDLE captures a and b;
// the difference is then produced one bit per clock, LSB first, through a
// borrow flop. diff/borrow are published on entry to DONE, which lasts one
// cycle and is flagged by done.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, only honoured in IDLE
//   a, b   : minuend / subtrahend, sampled on the accepting edge
//   busy   : high whenever the FSM is not in IDLE
//   done   : one-cycle pulse while in DONE
//   diff   : (a - b) mod 2^WIDTH, held until the next operation completes
//   borrow : 1 iff a < b, held like diff
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // One extra counter bit so the count can reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             bflop;
  logic [CNT_W-1:0] cnt;

  logic d1;
  logic bo1;
  logic dbit;
  logic bo2;
  logic bo_next;
  logic last_bit;

  // Full subtractor built as two half subtractors: first sa[0]-sb[0],
  // then subtract the incoming borrow from that partial difference.
  half_subtractor hs_lo (
    .x  (sa[0]),
    .y  (sb[0]),
    .d  (d1),
    .bo (bo1)
  );

  half_subtractor hs_hi (
    .x  (d1),
    .y  (bflop),
    .d  (dbit),
    .bo (bo2)
  );

  assign bo_next  = bo1 | bo2;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath. The last SHIFT edge also loads diff/borrow directly from the
  // final full-subtractor result, so they are already valid in the DONE
  // cycle and otherwise untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bflop  <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            bflop <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          res   <= {dbit, res[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          bflop <= bo_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff   <= {dbit, res[WIDTH-1:1]};
            borrow <= bo_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. A WIDTH=8 instance covers the
// directed and random cases, back-to-back starts, result hold and async
// reset; a WIDTH=4 instance is checked exhaustively. Expected values come
// from plain unsigned arithmetic on the operands.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;

  int total;
  int bad;

  logic [7:0] lastDiff;
  logic       lastBorrow;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one WIDTH=8 operation; entered and left at a falling edge with the
  // DUT idle. Operands are scrambled right after the accepting edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int k;
    int busyCnt;
    logic [7:0] ed;
    logic eb;
    ed = av - bv;
    eb = (av < bv);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    k = 0;
    busyCnt = 0;
    while (done8 !== 1'b1 && k < 40) begin
      if (busy8) busyCnt++;
      @(negedge clk);
      k++;
    end
    if (busy8) busyCnt++;
    checkOutput({tag, "_latency"}, k, 8);
    checkOutput({tag, "_busycycles"}, busyCnt, 9);
    checkOutput({tag, "_diff"}, diff8, ed);
    checkOutput({tag, "_borrow"}, borrow8, eb);
    lastDiff = ed;
    lastBorrow = eb;
    @(negedge clk);
    checkOutput({tag, "_donefall"}, done8, 0);
    checkOutput({tag, "_busyfall"}, busy8, 0);
  endtask

  task automatic runOp4(input logic [3:0] av, input logic [3:0] bv);
    int k;
    logic [3:0] ed;
    ed = av - bv;
    a4 = av;
    b4 = bv;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (done4 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("w4_latency", k, 4);
    checkOutput("w4_diff", diff4, ed);
    checkOutput("w4_borrow", borrow4, av < bv);
    @(negedge clk);
    checkOutput("w4_busyfall", busy4, 0);
  endtask

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  initial begin
    logic [7:0] ea;
    logic [7:0] eb;
    total = 0;
    bad = 0;
    lastDiff = '0;
    lastBorrow = 1'b0;
    rst_n = 1'b0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;

    #2;
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    checkOutput("rst_diff", diff8, 0);
    checkOutput("rst_borrow", borrow8, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'd200, 8'd55, "s200_55");
    applyStimulus(8'd5, 8'd10, "s5_10");
    applyStimulus(8'd0, 8'd1, "s0_1");
    applyStimulus(8'd255, 8'd255, "s255_255");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), "rand");
    end

    // Start held high with operands changing every cycle: only the values
    // present at edges 0, 10 and 20 are accepted.
    for (int t = 0; t < 30; t++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      start8 = 1'b1;
      if (t % 10 == 0) begin
        qa.push_back(a8);
        qb.push_back(b8);
      end
      @(negedge clk);
      checkOutput("hold_start_done", done8, (t % 10 == 8) ? 1 : 0);
      if (done8 === 1'b1 && qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        checkOutput("hold_start_diff", diff8, 8'(ea - eb));
        checkOutput("hold_start_borrow", borrow8, (ea < eb) ? 1 : 0);
        lastDiff = ea - eb;
        lastBorrow = (ea < eb);
      end
    end
    start8 = 1'b0;
    checkOutput("hold_start_all_done", qa.size(), 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_diff", diff8, lastDiff);
      checkOutput("idle_borrow", borrow8, lastBorrow);
      checkOutput("idle_done", done8, 0);
    end

    // Async reset four bits into an operation.
    a8 = 8'd37;
    b8 = 8'd90;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_done", done8, 0);
    checkOutput("abort_diff", diff8, 0);
    checkOutput("abort_borrow", borrow8, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_nodone", done8, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("abort_nodone_after", done8, 0);
    end
    applyStimulus(8'd100, 8'd99, "s100_99");

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        runOp4(4'(x), 4'(y));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
